// File: rtl/alu_exec_unit.sv
// alu_exec_unit: ALU with a two-entry result FIFO and valid/ready handshakes on both sides.
module alu_exec_unit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       Operation,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic             Illegal
);
    logic [WIDTH-1:0] res_mem [DEPTH];
    logic [DEPTH-1:0] zero_mem;
    logic [DEPTH-1:0] ill_mem;
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             ready_en;
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             push;
    logic             pop;

    // ready_en keeps in_ready low through reset and for the first edge after release
    assign in_ready  = ready_en & (count < 2'd2);
    assign out_valid = count != 2'd0;
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;
    assign ALUResult = res_mem[rd_ptr];
    assign Zero      = zero_mem[rd_ptr];
    assign Illegal   = ill_mem[rd_ptr];

    // Decode the operation; unsupported codes yield a zero result flagged illegal
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (Operation)
            4'b0000: alu_res = A & B;
            4'b0001: alu_res = A | B;
            4'b0010: alu_res = A + B;
            4'b0110: alu_res = A - B;
            4'b0111: alu_res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b1100: alu_res = A ^ B;
            default: alu_ill = 1'b1;
        endcase
    end

    // FIFO storage, pointers and occupancy; reset clears every entry so outputs read zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) res_mem[i] <= '0;
            zero_mem <= '0;
            ill_mem  <= '0;
            wr_ptr   <= 1'b0;
            rd_ptr   <= 1'b0;
            count    <= 2'd0;
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (push) begin
                res_mem[wr_ptr]  <= alu_res;
                zero_mem[wr_ptr] <= alu_res == '0;
                ill_mem[wr_ptr]  <= alu_ill;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end
endmodule
